// File: rtl/pl_book_sync_ctrl.sv
// -----------------------------------------------------------------------------
// pl_book_sync_ctrl
//
// Walks the single-symbol PL order book through the depth-sync procedure:
// clear the book, load a REST snapshot, bridge onto the live diff stream,
// then keep checking update-id continuity. Any id gap clears the book and
// asks for a fresh snapshot. This block is the only driver of the order
// book's event interface.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   snap_valid/ready    snapshot level handshake (accepted on valid&ready)
//   snap_ev             snapshot level
//   snap_id             snapshot lastUpdateId (constant across a snapshot)
//   snap_last           last level of the snapshot
//   live_valid/ready    live diff level handshake (accepted on valid&ready)
//   live_ev             live level
//   live_first_id       message first update id U (constant across message)
//   live_last_id        message last update id u (constant across message)
//   live_last           last level of the live message
//   snap_req            level: a new snapshot is needed
//   ob_clear            one-cycle pulse: wipe the order book
//   ob_valid, ob_ev     one-cycle event strobe and event to the order book
//   synced              high while the book follows the live stream
//   gap_cnt, drop_cnt   saturating counts of gaps / stale messages dropped
// -----------------------------------------------------------------------------
package binance_depth_types;

   typedef struct packed {
      logic        side;   // 0 = bid, 1 = ask
      logic [31:0] price;
      logic [31:0] qty;
   } depth_event_t;

endpackage

module pl_book_sync_ctrl
   import binance_depth_types::*;
#(
   parameter int ID_WIDTH  = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 snap_valid,
   output logic                 snap_ready,
   input  depth_event_t         snap_ev,
   input  logic [ID_WIDTH-1:0]  snap_id,
   input  logic                 snap_last,
   input  logic                 live_valid,
   output logic                 live_ready,
   input  depth_event_t         live_ev,
   input  logic [ID_WIDTH-1:0]  live_first_id,
   input  logic [ID_WIDTH-1:0]  live_last_id,
   input  logic                 live_last,
   output logic                 snap_req,
   output logic                 ob_clear,
   output logic                 ob_valid,
   output depth_event_t         ob_ev,
   output logic                 synced,
   output logic [CNT_WIDTH-1:0] gap_cnt,
   output logic [CNT_WIDTH-1:0] drop_cnt
);

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_WAIT_SNAP,
      ST_LOAD_SNAP,
      ST_SYNC,
      ST_LIVE
   } state_t;

   // What happens to every beat of the live message in flight.
   typedef enum logic [1:0] {
      ACT_FWD,
      ACT_DROP,
      ACT_GAP
   } act_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [ID_WIDTH:0]    ID_ONE  = (ID_WIDTH + 1)'(1);

   state_t                state_q, state_d;
   logic                  rst_done_q;
   logic [ID_WIDTH-1:0]   base_id_q, base_id_d;
   logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
   logic                  msg_start_q, msg_start_d;
   act_t                  msg_act_q, msg_act_d;
   logic                  ob_valid_q, ob_valid_d;
   depth_event_t          ob_ev_q, ob_ev_d;
   logic [CNT_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

   // Ids are compared one bit wider so that id+1 of an all-ones id cannot
   // wrap around and alias a small id.
   logic [ID_WIDTH:0]     first_ext, last_ext;
   logic [ID_WIDTH:0]     base_ext, base_p1;
   logic [ID_WIDTH:0]     prev_ext, prev_p1;
   act_t                  live_decision;
   act_t                  cur_act;

   assign first_ext = {1'b0, live_first_id};
   assign last_ext  = {1'b0, live_last_id};
   assign base_ext  = {1'b0, base_id_q};
   assign base_p1   = base_ext + ID_ONE;
   assign prev_ext  = {1'b0, last_id_q};
   assign prev_p1   = prev_ext + ID_ONE;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Verdict for a message, only meaningful on its first beat.
   // SYNC bridges against the snapshot id, LIVE checks strict continuity.
   always_comb begin
      live_decision = ACT_GAP;
      if (state_q == ST_SYNC) begin
         if (last_ext <= base_ext) begin
            live_decision = ACT_DROP;
         end else if (first_ext <= base_p1) begin
            live_decision = ACT_FWD;
         end
      end else begin
         if (first_ext == prev_p1) begin
            live_decision = ACT_FWD;
         end else if (last_ext <= prev_ext) begin
            live_decision = ACT_DROP;
         end
      end
   end

   assign cur_act = msg_start_q ? live_decision : msg_act_q;

   // Next-state and output decode.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      base_id_d   = base_id_q;
      last_id_d   = last_id_q;
      msg_start_d = msg_start_q;
      msg_act_d   = msg_act_q;
      ob_valid_d  = 1'b0;
      ob_ev_d     = ob_ev_q;
      gap_cnt_d   = gap_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      snap_ready  = 1'b0;
      live_ready  = 1'b0;
      snap_req    = 1'b0;
      ob_clear    = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            // The first cycle out of reset is spent idle so the clear pulse
            // is never hidden under the reset itself.
            ob_clear    = rst_done_q;
            msg_start_d = 1'b1;
            if (rst_done_q) begin
               state_d = ST_WAIT_SNAP;
            end
         end

         ST_WAIT_SNAP: begin
            snap_req   = 1'b1;
            snap_ready = 1'b1;
            if (snap_valid) begin
               base_id_d  = snap_id;
               ob_valid_d = 1'b1;
               ob_ev_d    = snap_ev;
               state_d    = snap_last ? ST_SYNC : ST_LOAD_SNAP;
            end
         end

         ST_LOAD_SNAP: begin
            snap_ready = 1'b1;
            if (snap_valid) begin
               ob_valid_d = 1'b1;
               ob_ev_d    = snap_ev;
               if (snap_last) begin
                  state_d = ST_SYNC;
               end
            end
         end

         ST_SYNC, ST_LIVE: begin
            live_ready = 1'b1;
            if (live_valid) begin
               if (msg_start_q) begin
                  msg_act_d = live_decision;
                  case (live_decision)
                     ACT_FWD:  last_id_d  = live_last_id;
                     ACT_DROP: drop_cnt_d = sat_inc(drop_cnt_q);
                     default:  gap_cnt_d  = sat_inc(gap_cnt_q);
                  endcase
               end
               if (cur_act == ACT_FWD) begin
                  ob_valid_d = 1'b1;
                  ob_ev_d    = live_ev;
               end
               msg_start_d = live_last;
               if (live_last) begin
                  if (cur_act == ACT_GAP) begin
                     state_d = ST_CLEAR;
                  end else if (cur_act == ACT_FWD && state_q == ST_SYNC) begin
                     state_d = ST_LIVE;
                  end
               end
            end
         end

         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         rst_done_q  <= 1'b0;
         base_id_q   <= '0;
         last_id_q   <= '0;
         msg_start_q <= 1'b1;
         msg_act_q   <= ACT_DROP;
         ob_valid_q  <= 1'b0;
         ob_ev_q     <= '0;
         gap_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, regardless of statement order.
         state_q     <= state_d;
         rst_done_q  <= 1'b1;
         base_id_q   <= base_id_d;
         last_id_q   <= last_id_d;
         msg_start_q <= msg_start_d;
         msg_act_q   <= msg_act_d;
         ob_valid_q  <= ob_valid_d;
         ob_ev_q     <= ob_ev_d;
         gap_cnt_q   <= gap_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign ob_valid = ob_valid_q;
   assign ob_ev    = ob_ev_q;
   assign gap_cnt  = gap_cnt_q;
   assign drop_cnt = drop_cnt_q;
   assign synced   = (state_q == ST_LIVE);

endmodule
